// File: rtl/dmem_arb.sv
// Data-memory port arbiter: the CPU shares one synchronous memory port with a burst DMA engine.
// The DMA engine uses the port when the CPU is idle, or takes it after STARVE_MAX consecutive CPU cycles.
module dmem_arb #(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cpu_addr,
    input  logic [3:0]  cpu_wr_en,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_rd,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic [31:0] dma_addr,
    input  logic [3:0]  dma_len,
    input  logic        dma_we,
    output logic        dma_gnt,
    input  logic [31:0] dma_wdata,
    output logic        dma_wack,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,
    output logic        dma_done,
    output logic        dma_busy,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_dout,
    output logic [3:0]  mem_wr_en,
    input  logic [31:0] mem_din
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        LAST  = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state;
    state_t      state_nxt;
    logic [29:0] beat_addr;
    logic [3:0]  beats_left;
    logic        burst_we;
    logic [3:0]  starve_cnt;
    logic        rvalid_q;

    logic        cpu_req;
    logic        dma_own;
    logic        accept;
    logic        last_beat;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^dma_addr[1:0];

    // A burst is only accepted from IDLE; gating with rst_n keeps dma_gnt low while reset is held.
    always_comb begin
        cpu_req   = cpu_rd | (|cpu_wr_en);
        dma_own   = (state == BURST) && (!cpu_req || (starve_cnt == STARVE_LIM));
        accept    = rst_n && (state == IDLE) && dma_req;
        last_beat = dma_own && (beats_left == 4'd0);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BURST;
            BURST:   if (last_beat) state_nxt = LAST;
            LAST:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = cpu_addr;
        mem_wr_en = cpu_wr_en;
        mem_dout  = cpu_wdata;
        cpu_stall = 1'b0;
        dma_wack  = 1'b0;
        if (dma_own) begin
            mem_addr  = {beat_addr, 2'b00};
            mem_wr_en = burst_we ? 4'b1111 : 4'b0000;
            mem_dout  = dma_wdata;
            dma_wack  = burst_we;
            cpu_stall = cpu_req;
        end
    end

    assign cpu_rdata  = mem_din;
    assign dma_rdata  = mem_din;
    assign dma_gnt    = accept;
    assign dma_rvalid = rvalid_q;
    assign dma_done   = (state == LAST);
    assign dma_busy   = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Burst context is latched on accept so the requester may change dma_* once granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_addr  <= 30'd0;
            beats_left <= 4'd0;
            burst_we   <= 1'b0;
        end else if (accept) begin
            beat_addr  <= dma_addr[31:2];
            beats_left <= dma_len;
            burst_we   <= dma_we;
        end else if (dma_own) begin
            beat_addr  <= beat_addr + 30'd1;
            beats_left <= beats_left - 4'd1;
        end
    end

    // Counts CPU-won cycles while a beat waits; reaching the limit hands the next cycle to DMA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
        end else if (state != BURST || dma_own) begin
            starve_cnt <= 4'd0;
        end else if (cpu_req && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= dma_own && !burst_we;
        end
    end

endmodule

// File: tb/tb_dmem_arb.sv
// Directed bench for dmem_arb with a synchronous memory model and DMA beat scoreboards.
module tb_dmem_arb;

    logic        clk;
    logic        rst_n;
    logic [31:0] cpu_addr;
    logic [3:0]  cpu_wr_en;
    logic [31:0] cpu_wdata;
    logic        cpu_rd;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dma_req;
    logic [31:0] dma_addr;
    logic [3:0]  dma_len;
    logic        dma_we;
    logic        dma_gnt;
    logic [31:0] dma_wdata;
    logic        dma_wack;
    logic        dma_rvalid;
    logic [31:0] dma_rdata;
    logic        dma_done;
    logic        dma_busy;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic [3:0]  mem_wr_en;
    logic [31:0] mem_din;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_exp_t;

    wr_exp_t     wq[$];
    logic [31:0] rq[$];
    logic [31:0] mem[logic [29:0]];
    logic [31:0] wbase;
    int          wbeat;
    int          checks;
    int          errors;

    dmem_arb #(.STARVE_MAX(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_addr   (cpu_addr),
        .cpu_wr_en  (cpu_wr_en),
        .cpu_wdata  (cpu_wdata),
        .cpu_rd     (cpu_rd),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .dma_req    (dma_req),
        .dma_addr   (dma_addr),
        .dma_len    (dma_len),
        .dma_we     (dma_we),
        .dma_gnt    (dma_gnt),
        .dma_wdata  (dma_wdata),
        .dma_wack   (dma_wack),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .dma_done   (dma_done),
        .dma_busy   (dma_busy),
        .mem_addr   (mem_addr),
        .mem_dout   (mem_dout),
        .mem_wr_en  (mem_wr_en),
        .mem_din    (mem_din)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] read_word(input logic [29:0] idx);
        return mem.exists(idx) ? mem[idx] : 32'h0;
    endfunction

    // Synchronous memory: registered read of the old contents, byte-lane writes.
    always @(posedge clk) begin
        automatic logic [31:0] rd = read_word(mem_addr[31:2]);
        automatic logic [31:0] wr = rd;
        mem_din <= rd;
        if (|mem_wr_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_wr_en[b]) wr[8*b +: 8] = mem_dout[8*b +: 8];
            mem[mem_addr[31:2]] = wr;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every DMA write beat and every read return must match the next queued entry.
    always @(negedge clk) begin
        if (dma_wack) begin
            if (wq.size() == 0) begin
                check_output("wack_unexpected", 32'(dma_wack), 32'd0);
            end else begin
                automatic wr_exp_t e = wq.pop_front();
                check_output("wbeat_addr", mem_addr, e.addr);
                check_output("wbeat_data", mem_dout, e.data);
                check_output("wbeat_wr_en", 32'(mem_wr_en), 32'hF);
            end
        end
        if (dma_rvalid) begin
            if (rq.size() == 0) begin
                check_output("rvalid_unexpected", 32'(dma_rvalid), 32'd0);
            end else begin
                check_output("rbeat_data", dma_rdata, rq.pop_front());
            end
        end
    end

    task automatic apply_stimulus(input logic rd, input logic [3:0] wr_en,
                                  input logic [31:0] addr, input logic [31:0] wdata);
        cpu_rd    = rd;
        cpu_wr_en = wr_en;
        cpu_addr  = addr;
        cpu_wdata = wdata;
    endtask

    task automatic start_burst(input logic [31:0] addr, input logic [3:0] len, input logic we);
        dma_req  = 1'b1;
        dma_addr = addr;
        dma_len  = len;
        dma_we   = we;
    endtask

    // Called at the negedge; advances the DMA write data when the beat was consumed.
    task automatic next_cycle();
        automatic logic w = dma_wack;
        @(posedge clk);
        #1;
        if (w) begin
            wbeat++;
            dma_wdata = wbase + 32'(wbeat);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        wbase  = 32'h0;
        wbeat  = 0;
        rst_n  = 1'b0;
        dma_req = 1'b0;
        dma_addr = 32'h0;
        dma_len = 4'd0;
        dma_we = 1'b0;
        dma_wdata = 32'h0;
        apply_stimulus(1'b0, 4'h0, 32'h0, 32'h0);

        // Reset: CPU still owns the port, DMA request is not granted.
        @(posedge clk);
        #1;
        start_burst(32'h200, 4'd3, 1'b1);
        apply_stimulus(1'b0, 4'hF, 32'h40, 32'h12345678);
        @(negedge clk);
        check_output("rst_gnt", 32'(dma_gnt), 32'd0);
        check_output("rst_busy", 32'(dma_busy), 32'd0);
        check_output("rst_done", 32'(dma_done), 32'd0);
        check_output("rst_rvalid", 32'(dma_rvalid), 32'd0);
        check_output("rst_stall", 32'(cpu_stall), 32'd0);
        check_output("rst_mem_wr_en", 32'(mem_wr_en), 32'hF);
        @(posedge clk);
        #1;
        dma_req = 1'b0;
        apply_stimulus(1'b0, 4'h0, 32'h0, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("post_rst_busy", 32'(dma_busy), 32'd0);
        next_cycle();

        // CPU store then load with DMA idle.
        apply_stimulus(1'b0, 4'hF, 32'h100, 32'hDEADBEEF);
        @(negedge clk);
        check_output("sw_wr_en", 32'(mem_wr_en), 32'hF);
        check_output("sw_addr", mem_addr, 32'h100);
        check_output("sw_dout", mem_dout, 32'hDEADBEEF);
        check_output("sw_stall", 32'(cpu_stall), 32'd0);
        next_cycle();
        apply_stimulus(1'b1, 4'h0, 32'h100, 32'h0);
        @(negedge clk);
        check_output("lw_wr_en", 32'(mem_wr_en), 32'h0);
        check_output("lw_stall", 32'(cpu_stall), 32'd0);
        next_cycle();
        apply_stimulus(1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        check_output("lw_rdata", cpu_rdata, 32'hDEADBEEF);
        next_cycle();

        // Four-beat write burst, CPU idle; dma_req held and dma_addr changed to show they are ignored.
        wbase = 32'hA000_0000;
        wbeat = 0;
        dma_wdata = wbase;
        for (int i = 0; i < 4; i++) wq.push_back('{32'h200 + 32'(4 * i), wbase + 32'(i)});
        start_burst(32'h200, 4'd3, 1'b1);
        @(negedge clk);
        check_output("wb_gnt", 32'(dma_gnt), 32'd1);
        check_output("wb_busy0", 32'(dma_busy), 32'd0);
        next_cycle();
        dma_addr = 32'h999;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_output("wb_addr", mem_addr, 32'h200 + 32'(4 * i));
            check_output("wb_wack", 32'(dma_wack), 32'd1);
            check_output("wb_gnt_ignored", 32'(dma_gnt), 32'd0);
            check_output("wb_done_early", 32'(dma_done), 32'd0);
            next_cycle();
        end
        @(negedge clk);
        check_output("wb_done", 32'(dma_done), 32'd1);
        check_output("wb_last_wack", 32'(dma_wack), 32'd0);
        check_output("wb_last_gnt", 32'(dma_gnt), 32'd0);
        next_cycle();
        dma_req = 1'b0;
        @(negedge clk);
        check_output("wb_idle_busy", 32'(dma_busy), 32'd0);
        check_output("wb_idle_done", 32'(dma_done), 32'd0);
        check_output("wb_drain", 32'(wq.size()), 32'd0);
        next_cycle();

        // Two-beat read burst against a CPU that reads every cycle: beats forced by starvation.
        mem[30'(32'h300 >> 2)] = 32'h1111_0000;
        mem[30'(32'h304 >> 2)] = 32'h1111_0001;
        rq.push_back(32'h1111_0000);
        rq.push_back(32'h1111_0001);
        apply_stimulus(1'b1, 4'h0, 32'h100, 32'h0);
        start_burst(32'h300, 4'd1, 1'b0);
        @(negedge clk);
        check_output("rb_gnt", 32'(dma_gnt), 32'd1);
        check_output("rb_stall0", 32'(cpu_stall), 32'd0);
        next_cycle();
        dma_req = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            automatic logic beat = (c == 4) || (c == 8);
            @(negedge clk);
            check_output("rb_stall", 32'(cpu_stall), 32'(beat));
            check_output("rb_addr", mem_addr,
                         (c == 4) ? 32'h300 : ((c == 8) ? 32'h304 : 32'h100));
            check_output("rb_rvalid", 32'(dma_rvalid), 32'((c == 5) || (c == 9)));
            check_output("rb_done", 32'(dma_done), 32'(c == 9));
            check_output("rb_wr_en", 32'(mem_wr_en), 32'h0);
            next_cycle();
        end
        @(negedge clk);
        check_output("rb_idle_busy", 32'(dma_busy), 32'd0);
        check_output("rb_idle_stall", 32'(cpu_stall), 32'd0);
        next_cycle();
        apply_stimulus(1'b0, 4'h0, 32'h0, 32'h0);

        // Read burst wrapping from the top word of the address space to address zero.
        mem[30'h3FFF_FFFF] = 32'hCAFE_0001;
        mem[30'h0]         = 32'hCAFE_0002;
        rq.push_back(32'hCAFE_0001);
        rq.push_back(32'hCAFE_0002);
        start_burst(32'hFFFF_FFFE, 4'd1, 1'b0);
        @(negedge clk);
        check_output("wrap_gnt", 32'(dma_gnt), 32'd1);
        next_cycle();
        dma_req = 1'b0;
        @(negedge clk);
        check_output("wrap_addr0", mem_addr, 32'hFFFF_FFFC);
        check_output("wrap_stall", 32'(cpu_stall), 32'd0);
        next_cycle();
        @(negedge clk);
        check_output("wrap_addr1", mem_addr, 32'h0000_0000);
        check_output("wrap_rvalid1", 32'(dma_rvalid), 32'd1);
        next_cycle();
        @(negedge clk);
        check_output("wrap_done", 32'(dma_done), 32'd1);
        check_output("wrap_rvalid2", 32'(dma_rvalid), 32'd1);
        next_cycle();
        @(negedge clk);
        check_output("wrap_rq_drain", 32'(rq.size()), 32'd0);
        next_cycle();

        // Reset asserted during beat 2 of a 16-beat write burst.
        wbase = 32'hB000_0000;
        wbeat = 0;
        dma_wdata = wbase;
        wq.push_back('{32'h400, wbase});
        wq.push_back('{32'h404, wbase + 32'd1});
        start_burst(32'h400, 4'd15, 1'b1);
        @(negedge clk);
        check_output("ab_gnt", 32'(dma_gnt), 32'd1);
        next_cycle();
        dma_req = 1'b0;
        @(negedge clk);
        check_output("ab_addr1", mem_addr, 32'h400);
        next_cycle();
        @(negedge clk);
        check_output("ab_addr2", mem_addr, 32'h404);
        check_output("ab_wack2", 32'(dma_wack), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("ab_busy", 32'(dma_busy), 32'd0);
        check_output("ab_wack", 32'(dma_wack), 32'd0);
        check_output("ab_done", 32'(dma_done), 32'd0);
        check_output("ab_rvalid", 32'(dma_rvalid), 32'd0);
        check_output("ab_wr_en", 32'(mem_wr_en), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_output("ab_post_busy", 32'(dma_busy), 32'd0);
        check_output("ab_post_done", 32'(dma_done), 32'd0);
        check_output("ab_post_addr", mem_addr, 32'h0);
        next_cycle();

        // A new single-beat write is accepted after release.
        wbase = 32'hC000_0000;
        wbeat = 0;
        dma_wdata = wbase;
        wq.push_back('{32'h500, wbase});
        start_burst(32'h500, 4'd0, 1'b1);
        @(negedge clk);
        check_output("nb_gnt", 32'(dma_gnt), 32'd1);
        next_cycle();
        dma_req = 1'b0;
        @(negedge clk);
        check_output("nb_wack", 32'(dma_wack), 32'd1);
        check_output("nb_addr", mem_addr, 32'h500);
        next_cycle();
        @(negedge clk);
        check_output("nb_done", 32'(dma_done), 32'd1);
        next_cycle();
        @(negedge clk);
        check_output("nb_busy", 32'(dma_busy), 32'd0);
        check_output("nb_wq_drain", 32'(wq.size()), 32'd0);
        check_output("nb_rq_drain", 32'(rq.size()), 32'd0);
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arb.md
DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 Parameter: STARVE_MAX, default 3, number of consecutive CPU-owned cycles a pending DMA beat tolerates before it is forced (1..15).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cpu_addr  input  32  CPU data address (from the data-memory stage).
REQ-005 cpu_wr_en  input  4  CPU byte write enables; bit3 = byte lane [31:24].
REQ-006 cpu_wdata  input  32  CPU write data, already lane-replicated.
REQ-007 cpu_rd  input  1  CPU read request this cycle.
REQ-008 cpu_rdata  output  32  read data to CPU, combinational copy of mem_din.
REQ-009 cpu_stall  output  1  CPU access not performed this cycle; CPU holds request.
REQ-010 dma_req  input  1  burst request; dma_addr/dma_len/dma_we valid while high.
REQ-011 dma_addr  input  32  burst start byte address; bits [1:0] ignored.
REQ-012 dma_len  input  4  burst length minus one (1..16 words).
REQ-013 dma_we  input  1  1 = write burst, 0 = read burst.
REQ-014 dma_gnt  output  1  one-cycle pulse: burst accepted and latched.
REQ-015 dma_wdata  input  32  write data for the current beat.
REQ-016 dma_wack  output  1  current write beat consumed; requester advances dma_wdata.
REQ-017 dma_rvalid  output  1  dma_rdata valid (one cycle after a read beat).
REQ-018 dma_rdata  output  32  read data to DMA, combinational copy of mem_din.
REQ-019 dma_done  output  1  one-cycle pulse after last beat issued.
REQ-020 dma_busy  output  1  state != IDLE.
REQ-021 mem_addr / mem_dout / mem_wr_en  output  32/32/4  shared synchronous memory port.
REQ-022 mem_din  input  32  memory read data, valid one cycle after address.

Function
REQ-023 States IDLE, BURST, LAST; IDLE->BURST on dma_req (dma_gnt=1, latch word address, beat count, direction); BURST->LAST when final beat issued; LAST->IDLE unconditionally.
REQ-024 cpu_req = cpu_rd | (|cpu_wr_en).
REQ-025 DMA owns the port in a cycle iff state==BURST and (cpu_req==0 or starve_cnt==STARVE_MAX); otherwise CPU owns it.
REQ-026 CPU-owned cycle: mem_addr=cpu_addr, mem_wr_en=cpu_wr_en, mem_dout=cpu_wdata, cpu_stall=0.
REQ-027 DMA-owned cycle: mem_addr={beat_addr,2'b00}, mem_wr_en=dma_we?4'b1111:4'b0000, mem_dout=dma_wdata, dma_wack=dma_we, cpu_stall=cpu_req.
REQ-028 starve_cnt: cleared on DMA beat and in IDLE/LAST; incremented on each BURST cycle where CPU owns with cpu_req=1; saturates at STARVE_MAX.
REQ-029 beat_addr increments by one word per DMA beat, wrapping modulo 2^32 bytes (0xFFFFFFFC -> 0x00000000).
REQ-030 dma_rvalid registered: high the cycle after a DMA read beat, including the cycle in LAST.
REQ-031 dma_done high exactly in LAST; dma_req in LAST or BURST ignored (accepted next IDLE cycle only).
REQ-032 In IDLE/LAST, CPU is never stalled; cpu_rdata valid the cycle after a CPU read it owned.
REQ-033 mem_dout when neither requester writes: don't-care; mem_wr_en SHALL be 0.

Reset
REQ-034 rst_n low (any time, incl. mid-burst): state=IDLE, starve_cnt=0, beat count=0, dma_gnt=dma_wack=dma_rvalid=dma_done=dma_busy=0, burst abandoned, no further beats.
REQ-035 During reset, mem_wr_en follows CPU ownership rules (CPU owns, cpu_stall=0).

Verification
REQ-036 Idle DMA, CPU SW 0xDEADBEEF @0x100 then LW @0x100 -> mem_wr_en=1111 then cpu_rdata=0xDEADBEEF next cycle, cpu_stall=0 throughout.
REQ-037 dma_req write, addr 0x200, len=3, CPU idle -> dma_gnt cycle 0, four beats 0x200..0x20C with dma_wack each, dma_done in cycle 5.
REQ-038 Read burst len=1 with cpu_rd held high continuously, STARVE_MAX=3 -> DMA beat after 3 CPU cycles, cpu_stall=1 that cycle, dma_rvalid next cycle; repeat for beat 2.
REQ-039 Read burst at 0xFFFFFFFC, len=1 -> second beat address 0x00000000.
REQ-040 rst_n pulsed low during beat 2 of a 16-beat burst -> outputs cleared immediately, no dma_done, dma_busy=0; new dma_req accepted after release.
